// File: rtl/wddl_nor_stage.sv
// WDDL dual-rail NOR2 stage: per-bit optional A inversion, registered output,
// precharge/evaluate sequencing with valid/ready handshake and rail checking.
module wddl_nor_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INV_A_MASK = '0,
    parameter int               PRE_CYCLES = 1,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_t,
    input  logic [WIDTH-1:0] a_f,
    input  logic [WIDTH-1:0] b_t,
    input  logic [WIDTH-1:0] b_f,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y_t,
    output logic [WIDTH-1:0] y_f,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             fault,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] eval_cnt
);

    localparam int CW = $clog2(PRE_CYCLES + 1);

    typedef enum logic [1:0] {PRE, READY, OUT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    pre_cnt;
    logic [WIDTH-1:0] ae_t, ae_f;
    logic [WIDTH-1:0] nor_t, nor_f;
    logic             word_ok;
    logic             accept;
    logic             out_done;

    // Inversion of A is a rail swap, so the gate itself stays positive logic.
    assign ae_t    = (a_f & INV_A_MASK) | (a_t & ~INV_A_MASK);
    assign ae_f    = (a_t & INV_A_MASK) | (a_f & ~INV_A_MASK);
    assign nor_t   = ae_f & b_f;
    assign nor_f   = ae_t | b_t;
    assign word_ok = (&(ae_t ^ ae_f)) & (&(b_t ^ b_f));

    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        y_valid   = 1'b0;
        accept    = 1'b0;
        out_done  = 1'b0;
        case (state)
            PRE: begin
                if (pre_cnt == CW'(1)) state_nxt = READY;
            end
            READY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = word_ok ? OUT : PRE;
                end
            end
            OUT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    out_done  = 1'b1;
                    state_nxt = PRE;
                end
            end
            default: state_nxt = PRE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PRE;
            pre_cnt <= CW'(PRE_CYCLES);
        end else begin
            state <= state_nxt;
            if (state_nxt == PRE && state != PRE)
                pre_cnt <= CW'(PRE_CYCLES);
            else if (state == PRE)
                pre_cnt <= pre_cnt - CW'(1);
        end
    end

    // Rails are loaded only on accept and cleared on the output handshake,
    // so they are 00 throughout PRE and READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_t <= '0;
            y_f <= '0;
        end else if (accept && word_ok) begin
            y_t <= nor_t;
            y_f <= nor_f;
        end else if (out_done) begin
            y_t <= '0;
            y_f <= '0;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     fault <= 1'b0;
        else if (accept && !word_ok) fault <= 1'b1;
        else if (fault_clr)          fault <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           eval_cnt <= '0;
        else if (out_done) eval_cnt <= eval_cnt + CNT_W'(1);
    end

endmodule

// File: doc/wddl_nor_stage.md
# wddl_nor_stage

Parametrised WDDL (wave dynamic differential logic) NOR stage: a WIDTH-bit vector of dual-rail NOR2 gates with a per-bit inverted-A option, followed by a registered, precharge-sequenced output with a valid/ready handshake. It sits between the dual-rail datapath cells of the AES core and the next register stage. It enforces the precharge/evaluate wave, checks rail integrity on every accepted word, and counts evaluations for the side-channel test harness.

## Interface
- WIDTH, 8: number of dual-rail bit pairs.
- INV_A_MASK, all zeros: WIDTH bits. A 1 in bit i inverts operand A for bit i, as in a NOR2B cell.
- PRE_CYCLES, 1: length of the precharge phase in clock cycles. Minimum 1.
- CNT_W, 16: width of the evaluation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_t, a_f  in  WIDTH  operand A, true and false rails.
- b_t, b_f  in  WIDTH  operand B, true and false rails.
- in_valid  in  1  input word offered.
- in_ready  out  1  stage ready to accept.
- y_t, y_f  out  WIDTH  result rails, registered.
- y_valid  out  1  result held on y_t/y_f.
- y_ready  in  1  downstream accepts the result.
- fault  out  1  sticky rail-integrity error.
- fault_clr  in  1  clears fault.
- eval_cnt  out  CNT_W  number of completed output handshakes, wraps.

## Operation
- Rail swap for inversion: for each bit i, if INV_A_MASK[i]=1 then ae_t=a_f and ae_f=a_t; otherwise ae_t=a_t and ae_f=a_f. Only positive logic is used.
- Per-bit NOR: y_t = ae_f & b_f; y_f = ae_t | b_t.
- Word validity: every pair (ae_t,ae_f) and (b_t,b_f) must be exactly 01 or 10. A pair of 00 or 11 in any bit makes the word invalid.
- FSM states: PRE, READY, OUT.
  - PRE: y_t=y_f=0. in_ready=0. y_valid=0. Down-counter loaded with PRE_CYCLES on entry. When the counter expires, go to READY.
  - READY: in_ready=1. y rails stay 0. On in_valid=1 with a valid word, register the NOR result and go to OUT. On in_valid=1 with an invalid word, set fault, drop the word, and go to PRE.
  - OUT: y_valid=1. y rails hold the result. in_ready=0 and inputs are ignored. On y_ready=1, increment eval_cnt (mod 2^CNT_W) and go to PRE. y_valid stays asserted until y_ready.
- fault: set by an invalid accepted word. Cleared by fault_clr. If set and clear happen in the same cycle, set wins and fault stays 1.
- Inputs are checked only on an accept cycle. Rail values outside READY are don't-care.

## Timing
- Reset (async): state=PRE with counter=PRE_CYCLES. y_t=y_f=0, y_valid=0, in_ready=0, fault=0, eval_cnt=0. Outputs go to these values immediately, without a clock edge. Reset mid-OUT discards the held result.
- After reset deasserts, in_ready rises after exactly PRE_CYCLES rising edges.
- Accept at edge N: y_valid=1 and result on the rails from cycle N+1. Latency is 1 cycle.
- Output handshake at edge M: the rails return to 00 in cycle M+1. PRE lasts PRE_CYCLES cycles, and in_ready=1 in cycle M+1+PRE_CYCLES.
- Invalid word at edge N: fault=1 in cycle N+1, y_valid never rises, in_ready returns in cycle N+1+PRE_CYCLES.
- Steady-state throughput: one word per PRE_CYCLES+2 cycles when y_ready is held at 1.
- Every valid output word is separated by a precharge of at least PRE_CYCLES cycles with both rails 0.
- No combinational path from inputs to y_t/y_f.

## Test plan
All scenarios use WIDTH=4, INV_A_MASK=4'b0001, PRE_CYCLES=2.
- Reset release: in_ready=0 for 2 cycles, then 1. All rails 0, fault=0, eval_cnt=0.
- Basic evaluation: a_t=0101, a_f=1010, b_t=0011, b_f=1100 accepted with y_ready=1 -> one cycle later y_t=1000, y_f=0111, y_valid=1. Next cycle: rails 0000/0000. eval_cnt=1.
- Backpressure: y_ready=0 for 5 cycles -> y_valid and rails stable for 5 cycles. in_ready=0 and in_valid pulses are ignored. The handshake completes on y_ready=1.
- Invalid rails: a_t=0001, a_f=0001 -> fault=1 next cycle, no y_valid, eval_cnt unchanged, in_ready back after 2 cycles. Then fault_clr and a new invalid word in the same cycle -> fault stays 1.
- Reset mid-OUT: assert rst while y_valid=1 -> y_valid=0 and rails 00 immediately, without waiting for a clock edge. eval_cnt=0.
- Counter wrap: with CNT_W=2, perform 5 handshakes -> eval_cnt sequence 1,2,3,0,1.
